systolic_feeder: RTL

Input-side sequencer for the 4x4 fixed-point systolic array. It holds one N x N operand matrix A and one N x N operand matrix B, each loaded through a simple write port. On `start` it clears the array's processing elements, then drives the left edge with the rows of A and the top edge with the columns of B. Each edge lane is skewed by one extra cycle per lane index, so matching operands meet in the correct processing element. It then keeps the array enabled for a fixed drain window and pulses `done` when the array's accumulators are final.

---
 rtl/systolic_feeder_if.sv | 35 +++
 rtl/systolic_feeder.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/systolic_feeder_if.sv
// Bus between the systolic feeder and whatever loads it and consumes its edges.
// Groups the operand write port, the run handshake (start/busy/done) and the
// array-facing drive signals (pe_rst, pe_en, a_edge, b_edge).
//   master : drives the write port and start, observes the rest (testbench / host)
//   slave  : the feeder itself
// N and W must match the parameters of the feeder instance that uses it.
interface systolic_feeder_if #(
  parameter int N = 4,
  parameter int W = 16
);
  localparam int IW = $clog2(N);

  logic          wr_en;
  logic          wr_sel;
  logic [IW-1:0] wr_row;
  logic [IW-1:0] wr_col;
  logic [W-1:0]  wr_data;
  logic          start;
  logic          busy;
  logic          done;
  logic          pe_rst;
  logic          pe_en;
  logic [N*W-1:0] a_edge;
  logic [N*W-1:0] b_edge;

  modport master (
    output wr_en, wr_sel, wr_row, wr_col, wr_data, start,
    input  busy, done, pe_rst, pe_en, a_edge, b_edge
  );

  modport slave (
    input  wr_en, wr_sel, wr_row, wr_col, wr_data, start,
    output busy, done, pe_rst, pe_en, a_edge, b_edge
  );
endinterface

// File: rtl/systolic_feeder.sv
// Input-side sequencer for an N x N systolic array.
// Holds operand matrices A and B (loaded through the bus write port while idle).
// On start: one cycle of PE clear, 2N-1 cycles streaming skewed rows of A on the
// left edge and skewed columns of B on the top edge, DRAIN_CYCLES enabled cycles
// of zeros, then a one-cycle done pulse.
// Ports:
//   clk  - clock
//   rst  - synchronous, active-high reset (clears state, outputs and operand store)
//   bus  - systolic_feeder_if.slave: wr_en/wr_sel/wr_row/wr_col/wr_data, start,
//          busy, done, pe_rst, pe_en, a_edge (lane i = row i), b_edge (lane j = col j)
// All outputs are registered; each state's output values are loaded on the edge
// that enters that state.
module systolic_feeder #(
  parameter int N            = 4,
  parameter int W            = 16,
  parameter int DRAIN_CYCLES = 8
) (
  input logic clk,
  input logic rst,
  systolic_feeder_if.slave bus
);
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(2*N + DRAIN_CYCLES + 1);
  localparam logic [CW-1:0] T_LAST = CW'(2*N - 2);
  localparam logic [CW-1:0] D_LAST = CW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, DONE} state_t;

  state_t        state_reg;
  logic [CW-1:0] cnt_reg;

  logic [W-1:0] a_store [N][N];
  logic [W-1:0] b_store [N][N];

  // Stream index that the edges will carry in the next cycle: 0 when leaving
  // CLEAR, cnt+1 while advancing through STREAM.
  logic [CW-1:0]  t_next;
  logic [N*W-1:0] a_next;
  logic [N*W-1:0] b_next;

  assign t_next = (state_reg == STREAM) ? cnt_reg + 1'b1 : '0;

  // Lane gi is delayed by gi cycles: it carries element (t - gi) of its row/column
  // while that index is inside the matrix, and zero before and after.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
      logic [IW-1:0] off;
      logic          in_win;
      assign off    = IW'(t_next - CW'(gi));
      assign in_win = (t_next >= CW'(gi)) && (t_next < CW'(gi + N));
      assign a_next[gi*W +: W] = in_win ? a_store[gi][off] : '0;
      assign b_next[gi*W +: W] = in_win ? b_store[off][gi] : '0;
    end
  endgenerate

  // Operand store: writable only while idle, so a running stream never sees a
  // half-updated matrix. A write in the same cycle as start lands before the
  // first edge value is read.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          a_store[r][c] <= '0;
          b_store[r][c] <= '0;
        end
      end
    end else if (state_reg == IDLE && bus.wr_en) begin
      if (bus.wr_sel) b_store[bus.wr_row][bus.wr_col] <= bus.wr_data;
      else            a_store[bus.wr_row][bus.wr_col] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.pe_rst <= 1'b0;
      bus.pe_en  <= 1'b0;
      bus.a_edge <= '0;
      bus.b_edge <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            state_reg  <= CLEAR;
            bus.busy   <= 1'b1;
            bus.pe_rst <= 1'b1;
          end
        end
        CLEAR: begin
          state_reg  <= STREAM;
          cnt_reg    <= '0;
          bus.pe_rst <= 1'b0;
          bus.pe_en  <= 1'b1;
          bus.a_edge <= a_next;
          bus.b_edge <= b_next;
        end
        STREAM: begin
          if (cnt_reg == T_LAST) begin
            state_reg  <= DRAIN;
            cnt_reg    <= '0;
            bus.a_edge <= '0;
            bus.b_edge <= '0;
          end else begin
            cnt_reg    <= cnt_reg + 1'b1;
            bus.a_edge <= a_next;
            bus.b_edge <= b_next;
          end
        end
        DRAIN: begin
          if (cnt_reg == D_LAST) begin
            state_reg <= DONE;
            cnt_reg   <= '0;
            bus.pe_en <= 1'b0;
            bus.done  <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          bus.done  <= 1'b0;
          bus.busy  <= 1'b0;
        end
        default: begin
          state_reg  <= IDLE;
          cnt_reg    <= '0;
          bus.busy   <= 1'b0;
          bus.done   <= 1'b0;
          bus.pe_rst <= 1'b0;
          bus.pe_en  <= 1'b0;
          bus.a_edge <= '0;
          bus.b_edge <= '0;
        end
      endcase
    end
  end
endmodule
